// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative radix-2 multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } mult_state_e;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_iter.sv
// Iterative shift-add multiplier: one radix-2 step per cycle, valid/ready on both sides.
// Optional two's-complement operands enabled by defining MULT_SIGNED_EN (adds signed_mode).
module mult_iter
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned OUT_FULL = 0,
  localparam int unsigned PW      = (OUT_FULL != 0) ? 2 * WIDTH : WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULT_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW-1:0]    p
);

  localparam int unsigned AW = 2 * WIDTH;
  localparam int unsigned CW = cnt_width(WIDTH);

  mult_state_e      state_q;
  logic [AW-1:0]    acc_q;
  logic [AW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             neg_d;
  logic [AW-1:0]    sum;
  logic [AW-1:0]    acc_final;

  // Operands are multiplied as magnitudes; the sign is reapplied on the last step.
  always_comb begin
    a_mag = a;
    b_mag = b;
    neg_d = 1'b0;
`ifdef MULT_SIGNED_EN
    if (signed_mode) begin
      a_mag = a[WIDTH-1] ? -a : a;
      b_mag = b[WIDTH-1] ? -b : b;
      neg_d = a[WIDTH-1] ^ b[WIDTH-1];
    end
`endif
  end

  assign sum       = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign acc_final = neg_q ? -sum : sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q    <= StRun;
            in_ready_q <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= {{WIDTH{1'b0}}, a_mag};
            mplier_q   <= b_mag;
            cnt_q      <= CW'(WIDTH);
            neg_q      <= neg_d;
          end
        end
        StRun: begin
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            acc_q       <= acc_final;
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end else begin
            acc_q <= sum;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = acc_q[PW-1:0];

endmodule

// File: tb/tb_mult_iter.sv
// Directed and table-driven bench for mult_iter (WIDTH=16, truncated and full-width instances).
module tb_mult_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        signed_mode;
  logic [15:0] a;
  logic [15:0] b;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] p;
  logic        in_ready_f;
  logic        out_valid_f;
  logic [31:0] p_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_iter #(.WIDTH(16), .OUT_FULL(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
`ifdef MULT_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .p          (p)
  );

  mult_iter #(.WIDTH(16), .OUT_FULL(1)) dut_full (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready_f),
    .a          (a),
    .b          (b),
`ifdef MULT_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .out_valid  (out_valid_f),
    .out_ready  (out_ready),
    .p          (p_f)
  );

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        sm;
    logic [15:0] exp_p;
    logic [31:0] exp_full;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts an operation from IDLE and waits for out_valid; lat = cycles after acceptance.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic sm,
                        output int lat);
    a           = va;
    b           = vb;
    signed_mode = sm;
    in_valid    = 1'b1;
    step();
    in_valid    = 1'b0;
    a           = 16'($urandom);
    b           = 16'($urandom);
    signed_mode = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, "_valid_drop"}, 64'(out_valid), 64'(0));
    chk({name, "_ready_back"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    int          lat;
    int          results;
    int          last;
    int          cyc;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;
    step();
    step();
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_p", 64'(p), 64'(0));
    chk("reset_p_full", 64'(p_f), 64'(0));
    chk("reset_in_ready_full", 64'(in_ready_f), 64'(1));
    rst_n = 1'b1;

    vecs.push_back('{16'h0003, 16'h0005, 1'b0, 16'h000F, 32'h0000_000F});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 32'hFFFE_0001});
    vecs.push_back('{16'h0000, 16'h1234, 1'b0, 16'h0000, 32'h0000_0000});
    vecs.push_back('{16'h1234, 16'h0000, 1'b0, 16'h0000, 32'h0000_0000});
    vecs.push_back('{16'h0001, 16'hFFFF, 1'b0, 16'hFFFF, 32'h0000_FFFF});
    vecs.push_back('{16'h8000, 16'h0002, 1'b0, 16'h0000, 32'h0001_0000});
    vecs.push_back('{16'h1234, 16'h5678, 1'b0, 16'h0060, 32'h0626_0060});
    vecs.push_back('{16'h00FF, 16'h0101, 1'b0, 16'hFFFF, 32'h0000_FFFF});
    vecs.push_back('{16'hABCD, 16'h0002, 1'b0, 16'h579A, 32'h0001_579A});
`ifdef MULT_SIGNED_EN
    vecs.push_back('{16'hFFFD, 16'h0005, 1'b1, 16'hFFF1, 32'hFFFF_FFF1});
    vecs.push_back('{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 32'h0000_8000});
    vecs.push_back('{16'hFFFD, 16'hFFFB, 1'b1, 16'h000F, 32'h0000_000F});
    vecs.push_back('{16'hFFFD, 16'h0005, 1'b0, 16'hFFF1, 32'h0004_FFF1});
`endif

    foreach (vecs[i]) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].sm, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(17));
      chk($sformatf("vec%0d_p", i), 64'(p), 64'(vecs[i].exp_p));
      chk($sformatf("vec%0d_p_full", i), 64'(p_f), 64'(vecs[i].exp_full));
      chk($sformatf("vec%0d_valid_full", i), 64'(out_valid_f), 64'(1));
      consume($sformatf("vec%0d", i));
    end

    // Result held in DONE while out_ready is low; new operands must be ignored.
    run_op(16'd3, 16'd5, 1'b0, lat);
    in_valid = 1'b1;
    a        = 16'd7;
    b        = 16'd7;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("hold%0d_p", i), 64'(p), 64'(15));
      chk($sformatf("hold%0d_valid", i), 64'(out_valid), 64'(1));
      chk($sformatf("hold%0d_in_ready", i), 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;
    consume("hold");
    run_op(16'd2, 16'd3, 1'b0, lat);
    chk("after_hold_p", 64'(p), 64'(6));
    chk("after_hold_latency", 64'(lat), 64'(17));
    consume("after_hold");

    // Reset in the middle of RUN.
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("midrun_in_ready", 64'(in_ready), 64'(0));
    chk("midrun_out_valid", 64'(out_valid), 64'(0));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_p", 64'(p), 64'(0));
    chk("midrst_p_full", 64'(p_f), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    run_op(16'd7, 16'd9, 1'b0, lat);
    chk("post_rst_p", 64'(p), 64'(63));
    chk("post_rst_latency", 64'(lat), 64'(17));
    consume("post_rst");

    // Back-to-back stream; operands change every cycle so ignored ones would be visible.
    results     = 0;
    last        = -1;
    cyc         = 0;
    signed_mode = 1'b0;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    while (results < 1000 && cyc < 1000 * 18 + 200) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (in_ready) exp_q.push_back({16'h0, a} * {16'h0, b});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("b2b_spurious_result", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("b2b%0d_p", results), 64'(p), 64'(e[15:0]));
          chk($sformatf("b2b%0d_p_full", results), 64'(p_f), 64'(e));
        end
        if (last >= 0) chk($sformatf("b2b%0d_interval", results), 64'(cyc - last), 64'(18));
        last = cyc;
        results++;
      end
      step();
      cyc++;
    end
    chk("b2b_result_count", 64'(results), 64'(1000));
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_iter.md
MULT_ITER -- requirements
Module: mult_iter

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal range is 2 to 64.
REQ-002 Parameter OUT_FULL, default 0; 0 gives a product truncated to WIDTH bits, 1 gives the full 2*WIDTH-bit product.
REQ-003 Port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-004 Port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-005 Port in_valid, input, 1 bit; operands a and b are valid.
REQ-006 Port in_ready, output, 1 bit; the block accepts operands this cycle.
REQ-007 Port a, input, WIDTH bits, multiplicand.
REQ-008 Port b, input, WIDTH bits, multiplier.
REQ-009 Port signed_mode, input, 1 bit, present only with MULT_SIGNED_EN; 1 means a and b are two's complement.
REQ-010 Port out_valid, output, 1 bit; p holds a completed product.
REQ-011 Port out_ready, input, 1 bit; the consumer takes p.
REQ-012 Port p, output, PW bits, where PW = OUT_FULL ? 2*WIDTH : WIDTH; p is the product, low PW bits.

Function
REQ-013 State machine shall have three states: IDLE, RUN and DONE.
REQ-014 in_ready shall be 1 only in IDLE, and out_valid shall be 1 only in DONE.
REQ-015 Acceptance occurs on any IDLE cycle with in_valid=1: the block latches a, b (and signed_mode), clears the accumulator, loads the iteration counter with WIDTH and moves to RUN.
REQ-016 Each RUN cycle shall perform one radix-2 shift-add step (add the shifted multiplicand if the current multiplier LSB is 1, shift the multiplier right, decrement the counter).
REQ-017 RUN shall last exactly WIDTH cycles, then move to DONE; out_valid first rises WIDTH+1 cycles after the acceptance cycle.
REQ-018 In DONE, p and out_valid shall hold stable until out_ready=1; on that cycle the block moves to IDLE and out_valid drops the next cycle.
REQ-019 in_valid in RUN or DONE shall be ignored; no operands are latched and no error is raised.
REQ-020 The internal accumulator shall be 2*WIDTH bits; p shall be its low PW bits, so truncation equals modulo 2^WIDTH.
REQ-021 Zero operands shall take the full WIDTH-cycle latency; there is no early termination.
REQ-022 The sustained rate shall be one product per WIDTH+2 cycles with out_ready held at 1.

Reset
REQ-023 With rst_n=0 at a rising edge: state becomes IDLE, out_valid=0, p=0 and the counter is 0; in_ready is 1 from the first cycle after reset.
REQ-024 Reset in RUN or DONE shall abandon the operation with no partial result appearing on p.

Configuration
REQ-025 Macro MULT_SIGNED_EN, when defined, adds signed_mode, sampled only at acceptance.
REQ-026 With MULT_SIGNED_EN defined and signed_mode=1:
- operands are converted to magnitudes at acceptance;
- the sign is the XOR of the operand MSBs;
- the final accumulator is negated (two's complement) on entry to DONE, with no extra cycle;
- the most-negative operand value is handled correctly.
REQ-027 Without MULT_SIGNED_EN, the port is absent and all operands are unsigned.

Structure
REQ-028 Shared package mult_pkg shall hold the state enum typedef (IDLE/RUN/DONE) and the counter-width function (clog2 of WIDTH+1).
REQ-029 The block shall be a single module with no sub-module; the datapath is one adder plus shift registers.

Verification
REQ-030 WIDTH=16, OUT_FULL=0, a=3, b=5, out_ready=1 -> p=0x000F, with out_valid first high 17 cycles after acceptance.
REQ-031 a=0xFFFF, b=0xFFFF -> p=0x0001 with OUT_FULL=0, and p=0xFFFE0001 with OUT_FULL=1.
REQ-032 MULT_SIGNED_EN, signed_mode=1, a=0xFFFD (-3), b=5 -> p=0xFFF1; a=0x8000, b=0xFFFF with OUT_FULL=1 -> p=0x00008000.
REQ-033 out_ready held 0 for 10 cycles in DONE -> p and out_valid stable, in_ready=0, and a new in_valid is ignored; accepted on out_ready=1.
REQ-034 rst_n=0 for one cycle mid-RUN -> next cycle out_valid=0, p=0, in_ready=1; a subsequent 7*9 yields p=63.
REQ-035 Back-to-back operations with in_valid=1 and out_ready=1 throughout -> one result every 18 cycles (WIDTH=16), all correct against a reference model over 1000 random pairs.
